// File: rtl/div4_pkg.sv
// Shared constants and types for the divide-by-4 request scheduler.
package div4_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_REQ = 4;
  localparam int SERVED_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/div4_sched_rr_arb.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// returning a one-hot grant (gated by en) and the winner's index.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // rot[gi] is the request that sits gi positions after the pointer; N_REQ is
  // a power of two, so index wrap-around is plain truncation.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + IDX_W'(gi)];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = ptr + off;
    gnt = '0;
    if (en && (|rot)) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/div4_sched.sv
// Round-robin scheduler that grants one requester at a time and returns its
// operand divided by 4 through a valid/ready result port.
module div4_sched
  import div4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ-1:0][WIDTH-1:0]  data_i,
  output logic [N_REQ-1:0]             gnt_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(N_REQ)-1:0]     id_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [SERVED_W-1:0]          served_o
);

  localparam int IDX_W = $clog2(N_REQ);

  generate
    if (WIDTH < 3) begin : g_bad_width
      $error("div4_sched: WIDTH must be at least 3");
    end
    if ((N_REQ < 2) || (N_REQ > 8) || ((N_REQ & (N_REQ - 1)) != 0)) begin : g_bad_nreq
      $error("div4_sched: N_REQ must be a power of 2 between 2 and 8");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    data_reg, data_next;
  logic [IDX_W-1:0]    id_reg, id_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [SERVED_W-1:0] served_reg, served_next;

  logic                grant_ok;
  logic                handshake;
  logic [N_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;

  // Reset is folded in so no grant pulse can appear while rst_ni is low.
  assign grant_ok  = rst_ni & en_i & (|req_i) & ((state_reg == IDLE) | ready_i);
  assign handshake = (state_reg == RESP) & ready_i;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_reg),
    .en  (grant_ok),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    id_next     = id_reg;
    ptr_next    = ptr_reg;
    served_next = handshake ? served_reg + SERVED_W'(1) : served_reg;
    if (grant_ok) begin
      state_next = RESP;
      data_next  = {2'b00, data_i[arb_idx][WIDTH-1:2]};
      id_next    = arb_idx;
      ptr_next   = arb_idx + IDX_W'(1);
    end else if (handshake) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      data_reg   <= '0;
      id_reg     <= '0;
      ptr_reg    <= '0;
      served_reg <= '0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      id_reg     <= id_next;
      ptr_reg    <= ptr_next;
      served_reg <= served_next;
    end
  end

  assign gnt_o    = arb_gnt;
  assign data_o   = data_reg;
  assign id_o     = id_reg;
  assign valid_o  = (state_reg == RESP);
  assign served_o = served_reg;

endmodule

// File: tb/tb_div4_sched.sv
// Directed bench for div4_sched: grants push expected results to a queue that
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_div4_sched;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [3:0]      req_i;
  logic [3:0][3:0] data_i;
  logic [3:0]      gnt_o;
  logic [3:0]      data_o;
  logic [1:0]      id_o;
  logic            valid_o;
  logic            ready_i;
  logic [7:0]      served_o;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  div4_sched dut (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .gnt_o    (gnt_o),
    .data_o   (data_o),
    .id_o     (id_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .served_o (served_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_id", int'(id_o), int'(e.id));
        check("result_data", int'(data_o), int'(e.data));
        $display("handshake id=%0d data=%0h (expect id=%0d data=%0h) served=%0d",
                 id_o, data_o, e.id, e.data, served_o);
      end
    end
  end

  initial begin
    exp_t e;
    rst_ni  = 1'b0;
    en_i    = 1'b1;
    req_i   = 4'b1111;
    ready_i = 1'b1;
    data_i  = '0;

    // Reset, then idle; requests are held during reset to prove gnt_o stays 0.
    step();
    #1 check("rst_gnt", int'(gnt_o), 0);
    step();
    check("rst_valid", int'(valid_o), 0);
    check("rst_served", int'(served_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_id", int'(id_o), 0);
    #1 check("rst_gnt2", int'(gnt_o), 0);
    req_i  = 4'b0000;
    rst_ni = 1'b1;

    // Single request: 0xD / 4 = 3 from requester 2.
    step();
    req_i     = 4'b0100;
    data_i[2] = 4'hD;
    #1 check("single_gnt", int'(gnt_o), 4'b0100);
    e.id = 2'd2; e.data = 4'h3; exp_q.push_back(e);
    step();
    req_i = 4'b0000;
    check("single_valid", int'(valid_o), 1);
    check("single_data", int'(data_o), 3);
    check("single_id", int'(id_o), 2);
    step();
    check("single_idle_valid", int'(valid_o), 0);
    check("single_served", int'(served_o), 1);
    check("idle_keeps_data", int'(data_o), 3);

    // Fresh reset so the pointer starts at requester 0 for the fairness run.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    data_i[0] = 4'h4;
    data_i[1] = 4'h8;
    data_i[2] = 4'hC;
    data_i[3] = 4'hF;
    req_i     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 check("rr_gnt", int'(gnt_o), 1 << (i % 4));
      e.id = 2'(i % 4);
      e.data = data_i[i % 4] >> 2;
      exp_q.push_back(e);
      step();
    end
    req_i = 4'b0000;
    check("rr_served4", int'(served_o), 4);
    step();
    check("rr_served5", int'(served_o), 5);
    check("rr_idle", int'(valid_o), 0);

    // Backpressure: pointer now at 1; requester 1 asks twice.
    req_i     = 4'b0010;
    data_i[1] = 4'hA;
    #1 check("bp_gnt_first", int'(gnt_o), 4'b0010);
    e.id = 2'd1; e.data = 4'h2; exp_q.push_back(e);
    step();
    ready_i   = 1'b0;
    data_i[1] = 4'h7;
    for (int j = 0; j < 3; j++) begin
      #1 check("bp_gnt_blocked", int'(gnt_o), 0);
      check("bp_valid_hold", int'(valid_o), 1);
      check("bp_data_hold", int'(data_o), 2);
      check("bp_id_hold", int'(id_o), 1);
      step();
    end
    ready_i = 1'b1;
    #1 check("bp_gnt_release", int'(gnt_o), 4'b0010);
    e.id = 2'd1; e.data = 4'h1; exp_q.push_back(e);
    step();
    req_i = 4'b0000;
    check("bp_second_valid", int'(valid_o), 1);
    step();
    check("bp_idle", int'(valid_o), 0);
    check("bp_served", int'(served_o), 7);

    // Enable gating, then reset while a result is held.
    rst_ni = 1'b0;
    step();
    rst_ni    = 1'b1;
    en_i      = 1'b0;
    req_i     = 4'b0001;
    data_i[0] = 4'h9;
    for (int j = 0; j < 2; j++) begin
      #1 check("en_off_gnt", int'(gnt_o), 0);
      check("en_off_valid", int'(valid_o), 0);
      step();
    end
    en_i = 1'b1;
    #1 check("en_on_gnt", int'(gnt_o), 4'b0001);
    step();
    ready_i = 1'b0;
    req_i   = 4'b0000;
    en_i    = 1'b0;
    check("en_resp_valid", int'(valid_o), 1);
    check("en_resp_data", int'(data_o), 2);
    step();
    check("en_off_hold_valid", int'(valid_o), 1);
    check("en_off_hold_data", int'(data_o), 2);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("rst_resp_valid", int'(valid_o), 0);
    check("rst_resp_served", int'(served_o), 0);
    check("rst_resp_data", int'(data_o), 0);

    // Counter wrap: 256 back-to-back handshakes from requester 0.
    ready_i   = 1'b1;
    en_i      = 1'b1;
    req_i     = 4'b0001;
    data_i[0] = 4'h8;
    for (int i = 0; i < 256; i++) begin
      #1 if (gnt_o != 4'b0001) check("wrap_gnt", int'(gnt_o), 4'b0001);
      e.id = 2'd0; e.data = 4'h2; exp_q.push_back(e);
      step();
    end
    req_i = 4'b0000;
    check("wrap_served255", int'(served_o), 255);
    step();
    check("wrap_served0", int'(served_o), 0);
    check("wrap_idle", int'(valid_o), 0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
